// File: rtl/mem_port_arbiter_r32i.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_r32i
// Purpose  : Shares one 32-bit RAM port between the instruction-cache refill
//            engine (multi-beat burst reads) and the load/store unit (single
//            word reads/writes). Generates burst addresses, arbitrates with
//            data priority plus anti-starvation, and routes read data and
//            completion strobes back to the requester.
// Revision : 1.0 - initial release
//
// Build option:
//   BURST_PREEMPT_EN - when defined, a pending data access may slip in
//                      between two refill beats; the burst then resumes at
//                      the saved beat. When undefined, bursts are atomic.
//
// Ports:
//   clock_i, reset_ni              clock, asynchronous active-low reset
//   ins_req_i, ins_base_i          refill burst request and start address
//   ins_valid_o, ins_beat_o,
//   ins_rdata_o, ins_done_o        per-beat refill data and last-beat pulse
//   dat_req_i, dat_we_i, dat_addr_i,
//   dat_wdata_i, dat_be_i          single data access request
//   dat_ack_o, dat_rdata_o         data completion pulse and read data
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_be_o          RAM request side
//   mem_ack_i, mem_rdata_i         RAM completion and same-cycle read data
// ============================================================================
module mem_port_arbiter_r32i #(
  parameter int dataW    = 32,
  parameter int BurstLen = 32
) (
  input  logic                        clock_i,
  input  logic                        reset_ni,
  input  logic                        ins_req_i,
  input  logic [dataW-1:0]            ins_base_i,
  output logic                        ins_valid_o,
  output logic [$clog2(BurstLen)-1:0] ins_beat_o,
  output logic [dataW-1:0]            ins_rdata_o,
  output logic                        ins_done_o,
  input  logic                        dat_req_i,
  input  logic                        dat_we_i,
  input  logic [dataW-1:0]            dat_addr_i,
  input  logic [dataW-1:0]            dat_wdata_i,
  input  logic [3:0]                  dat_be_i,
  output logic                        dat_ack_o,
  output logic [dataW-1:0]            dat_rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [dataW-1:0]            mem_addr_o,
  output logic [dataW-1:0]            mem_wdata_o,
  output logic [3:0]                  mem_be_o,
  input  logic                        mem_ack_i,
  input  logic [dataW-1:0]            mem_rdata_i
);

  localparam int                BeatW    = $clog2(BurstLen);
  localparam logic [BeatW-1:0]  LastBeat = BeatW'(BurstLen - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DAT  = 2'd1,
    S_INS  = 2'd2
  } state_e;

  state_e           state_q;
  logic [BeatW-1:0] beat_q;
  logic [dataW-1:0] base_q;
  logic             last_dat_q;   // 1 = most recent completed grant was DAT
`ifdef BURST_PREEMPT_EN
  logic             resume_q;     // DAT access was taken out of a burst
`endif

  logic             ack_dat;
  logic             ack_ins;
  logic             in_dat;
  logic             in_ins;
  logic [dataW-1:0] ins_addr;

  assign in_dat   = (state_q == S_DAT);
  assign in_ins   = (state_q == S_INS);
  assign ack_dat  = in_dat && mem_ack_i;
  assign ack_ins  = in_ins && mem_ack_i;
  // Natural modulo-2^dataW addition: a burst crossing the top of the
  // address space wraps to zero silently.
  assign ins_addr = base_q + (dataW'(beat_q) << 2);

  // RAM side: everything is decoded from the registered state, so the
  // request and its fields stay put until the RAM acknowledges.
  assign mem_req_o   = in_dat || in_ins;
  assign mem_we_o    = in_dat && dat_we_i;
  assign mem_addr_o  = in_dat ? dat_addr_i  : (in_ins ? ins_addr : '0);
  assign mem_wdata_o = in_dat ? dat_wdata_i : '0;
  assign mem_be_o    = in_dat ? dat_be_i    : (in_ins ? 4'hF : 4'h0);

  // Requester side: strobes follow mem_ack in the same cycle; data buses
  // are forced to zero whenever their strobe is low.
  assign ins_valid_o = ack_ins;
  assign ins_beat_o  = ack_ins ? beat_q : '0;
  assign ins_rdata_o = ack_ins ? mem_rdata_i : '0;
  assign ins_done_o  = ack_ins && (beat_q == LastBeat);
  assign dat_ack_o   = ack_dat;
  assign dat_rdata_o = ack_dat ? mem_rdata_i : '0;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      last_dat_q <= 1'b1;
`ifdef BURST_PREEMPT_EN
      resume_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // Data wins ties, except when it also won last time and a refill
          // is waiting -- that keeps the refill engine from starving.
          if (dat_req_i && !(ins_req_i && last_dat_q)) begin
            state_q <= S_DAT;
          end else if (ins_req_i) begin
            state_q <= S_INS;
            base_q  <= ins_base_i;
            beat_q  <= '0;
          end
        end
        S_DAT: begin
          if (mem_ack_i) begin
`ifdef BURST_PREEMPT_EN
            if (resume_q) begin
              // Preemption leaves last_grant untouched; go straight back
              // to the interrupted burst at its saved beat.
              state_q  <= S_INS;
              resume_q <= 1'b0;
            end else begin
              state_q    <= S_IDLE;
              last_dat_q <= 1'b1;
            end
`else
            state_q    <= S_IDLE;
            last_dat_q <= 1'b1;
`endif
          end
        end
        S_INS: begin
          if (mem_ack_i) begin
            if (beat_q == LastBeat) begin
              state_q    <= S_IDLE;
              beat_q     <= '0;
              last_dat_q <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
`ifdef BURST_PREEMPT_EN
              if (dat_req_i) begin
                state_q  <= S_DAT;
                resume_q <= 1'b1;
              end
`endif
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter_r32i.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter_r32i
// Purpose  : Self-checking bench for mem_port_arbiter_r32i (BurstLen = 4).
//            A RAM responder with configurable latency answers every request;
//            each completed RAM transfer is recorded and compared, in order,
//            against a transaction list built from the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter_r32i;

  localparam int BL = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ins_req, dat_req, dat_we, mem_ack;
  logic [31:0] ins_base, dat_addr, dat_wdata, mem_rdata;
  logic [3:0]  dat_be;
  logic        ins_valid, ins_done, dat_ack, mem_req, mem_we;
  logic [1:0]  ins_beat;
  logic [31:0] ins_rdata, dat_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  mem_port_arbiter_r32i #(.dataW(32), .BurstLen(BL)) dut (
    .clock_i     (clk),
    .reset_ni    (rst_n),
    .ins_req_i   (ins_req),
    .ins_base_i  (ins_base),
    .ins_valid_o (ins_valid),
    .ins_beat_o  (ins_beat),
    .ins_rdata_o (ins_rdata),
    .ins_done_o  (ins_done),
    .dat_req_i   (dat_req),
    .dat_we_i    (dat_we),
    .dat_addr_i  (dat_addr),
    .dat_wdata_i (dat_wdata),
    .dat_be_i    (dat_be),
    .dat_ack_o   (dat_ack),
    .dat_rdata_o (dat_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  logic [138:0] all_outs;
  assign all_outs = {mem_req, mem_we, mem_addr, mem_wdata, mem_be, ins_valid,
                     ins_beat, ins_rdata, ins_done, dat_ack, dat_rdata};

  // kind: 2'b10 = refill beat, 2'b01 = data access
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  beat;
    logic        done;
    logic [31:0] rdata;
  } txn_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dreq_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  dreq_t       dat_pend[$];
  logic [31:0] ins_pend[$];
  int          dat_rd    = 0;
  int          ins_rd    = 0;
  int          spurious  = 0;
  int          unstable  = 0;
  int          req_rises = 0;
  int          lat_mode  = 0;   // <0: random 0..2 wait cycles per transfer
  bit          drv_clear = 1'b0;
  int          total     = 0;
  int          bad       = 0;

  function automatic logic [31:0] ramf(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // ---------------- reference model: transaction lists -----------------
  task automatic model_dat(input dreq_t r);
    txn_t t;
    t = '{kind:2'b01, addr:r.addr, we:r.we, wdata:r.wdata, be:r.be,
          beat:2'd0, done:1'b0, rdata:ramf(r.addr)};
    exp_q.push_back(t);
  endtask

  task automatic model_beats(input logic [31:0] base, input int first, input int last);
    txn_t t;
    for (int k = first; k <= last; k++) begin
      t = '{kind:2'b10, addr:base + 32'(4 * k), we:1'b0, wdata:32'h0, be:4'hF,
            beat:2'(k), done:(k == BL - 1), rdata:ramf(base + 32'(4 * k))};
      exp_q.push_back(t);
    end
  endtask

  function automatic dreq_t rand_dreq();
    dreq_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = $urandom & 32'hFFFF_FFFC;
    r.wdata = $urandom;
    r.be    = 4'($urandom);
    return r;
  endfunction

  // ---------------- requester drivers -----------------
  initial begin
    ins_req = 0; ins_base = 0; dat_req = 0; dat_we = 0;
    dat_addr = 0; dat_wdata = 0; dat_be = 0;
    forever begin
      @(negedge clk); #3;
      if (drv_clear) begin
        dat_req = 0; ins_req = 0;
        dat_rd = dat_pend.size(); ins_rd = ins_pend.size();
      end else begin
        if (dat_ack) dat_req = 0;
        else if (!dat_req && dat_rd < dat_pend.size()) begin
          {dat_we, dat_addr, dat_wdata, dat_be} = dat_pend[dat_rd];
          dat_rd++;
          dat_req = 1;
        end
        if (ins_done) ins_req = 0;
        else if (!ins_req && ins_rd < ins_pend.size()) begin
          ins_base = ins_pend[ins_rd];
          ins_rd++;
          ins_req = 1;
        end
      end
    end
  end

  // ---------------- RAM responder and transfer recorder -----------------
  initial begin
    int          cnt;
    int          lat;
    logic        prev_req;
    logic        prev_ack;
    logic [68:0] prev_f;
    txn_t        t;
    cnt = 0; lat = 0; prev_req = 0; prev_ack = 0; prev_f = '0;
    mem_ack = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!prev_req || prev_ack) begin
          cnt = 0;
          lat = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
        end
        if (cnt >= lat) begin
          mem_ack = 1; mem_rdata = ramf(mem_addr);
        end else begin
          mem_ack = 0; mem_rdata = $urandom; cnt++;
        end
      end else begin
        mem_ack = 0; mem_rdata = $urandom;
      end
      #1;
      if (mem_req && !prev_req) req_rises++;
      if (mem_req && prev_req && !prev_ack && ({mem_we, mem_addr, mem_wdata, mem_be} !== prev_f))
        unstable++;
      if (mem_req && mem_ack) begin
        t.kind  = {ins_valid, dat_ack};
        t.addr  = mem_addr;
        t.we    = mem_we;
        t.wdata = ins_valid ? 32'h0 : mem_wdata;
        t.be    = mem_be;
        t.beat  = ins_valid ? ins_beat : 2'd0;
        t.done  = ins_done;
        t.rdata = ins_valid ? ins_rdata : dat_rdata;
        obs_q.push_back(t);
      end else if (ins_valid || ins_done || dat_ack) begin
        spurious++;
      end
      prev_req = mem_req;
      prev_ack = mem_req && mem_ack;
      prev_f   = {mem_we, mem_addr, mem_wdata, mem_be};
    end
  end

  task automatic wait_quiet(output bit ok);
    int quiet;
    quiet = 0; ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #2;
      if (dat_rd == dat_pend.size() && ins_rd == ins_pend.size() &&
          !dat_req && !ins_req && !mem_req) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin ok = 1; break; end
    end
  endtask

  // ---------------- scenarios -----------------
  task automatic test_reset();
    bit ok; int ob, eb; dreq_t r;
    ob = obs_q.size(); eb = exp_q.size();
    lat_mode = 0;
    r = '{we:1'b0, addr:32'h40, wdata:32'h1111_2222, be:4'hF};
    dat_pend.push_back(r);
    ins_pend.push_back(32'h300);
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      total++;
      if (all_outs !== '0) begin bad++; $display("FAIL reset_outs cycle %0d got %h want 0", i, all_outs); end
    end
    rst_n = 1;
    // last_grant resets to DAT, so a waiting refill wins the first tie.
    @(negedge clk); #2;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h300}) begin
      bad++; $display("FAIL reset_first_grant got req=%b we=%b addr=%h want req=1 we=0 addr=00000300", mem_req, mem_we, mem_addr);
    end
    model_beats(32'h300, 0, BL - 1);
    model_dat(r);
    wait_quiet(ok);
    total++; if (!ok) begin bad++; $display("FAIL reset_timeout got busy want idle"); end
    total++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin bad++; $display("FAIL reset_count got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && ob + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL reset_txn %0d got %h want %h", i, obs_q[ob + i], exp_q[eb + i]); end
    end
  endtask

  task automatic test_data_read();
    bit ok, seen; int ob, eb; dreq_t r;
    ob = obs_q.size(); eb = exp_q.size();
    lat_mode = 2;
    r = '{we:1'b0, addr:32'h100, wdata:32'h0, be:4'hF};
    dat_pend.push_back(r);
    model_dat(r);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #2;
      if (dat_ack) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL read_ack_seen got 0 want 1"); end
    @(negedge clk); #2;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL read_req_drop got %b want 0", mem_req); end
    wait_quiet(ok);
    total++; if (!ok) begin bad++; $display("FAIL read_timeout got busy want idle"); end
    total++;
    if (obs_q.size() - ob != 1) begin bad++; $display("FAIL read_count got %0d want 1", obs_q.size() - ob); end
    for (int i = 0; i < exp_q.size() - eb && ob + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL read_txn %0d got %h want %h", i, obs_q[ob + i], exp_q[eb + i]); end
    end
  endtask

  task automatic test_burst(input logic [31:0] base);
    bit ok; int ob, eb;
    ob = obs_q.size(); eb = exp_q.size();
    lat_mode = 0;
    ins_pend.push_back(base);
    model_beats(base, 0, BL - 1);
    wait_quiet(ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_timeout base %h got busy want idle", base); end
    total++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin bad++; $display("FAIL burst_count got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && ob + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL burst_txn %0d got %h want %h", i, obs_q[ob + i], exp_q[eb + i]); end
    end
  endtask

  // Entered with last_grant = INS (previous test ends on a burst).
  task automatic test_contention();
    bit ok; int ob, eb, rises0; dreq_t a, b; logic [31:0] base;
    ob = obs_q.size(); eb = exp_q.size(); rises0 = req_rises;
    lat_mode = -1;
    a = rand_dreq(); b = rand_dreq();
    base = $urandom & 32'hFFFF_FFFC;
    dat_pend.push_back(a);
    dat_pend.push_back(b);
    ins_pend.push_back(base);
    model_dat(a);
`ifdef BURST_PREEMPT_EN
    model_beats(base, 0, 0);
    model_dat(b);
    model_beats(base, 1, BL - 1);
`else
    model_beats(base, 0, BL - 1);
    model_dat(b);
`endif
    wait_quiet(ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_timeout got busy want idle"); end
    total++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin bad++; $display("FAIL cont_count got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && ob + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL cont_txn %0d got %h want %h", i, obs_q[ob + i], exp_q[eb + i]); end
    end
    total++;
`ifdef BURST_PREEMPT_EN
    if (req_rises - rises0 != 2) begin bad++; $display("FAIL cont_req_rises got %0d want 2", req_rises - rises0); end
`else
    if (req_rises - rises0 != 3) begin bad++; $display("FAIL cont_req_rises got %0d want 3", req_rises - rises0); end
`endif
  endtask

  task automatic test_midburst_data();
    bit ok, seen; int ob, eb; dreq_t r; logic [31:0] base;
    ob = obs_q.size(); eb = exp_q.size();
    lat_mode = 0;
    base = $urandom & 32'hFFFF_FFFC;
    r = rand_dreq();
    ins_pend.push_back(base);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #2;
      if (ins_valid && ins_beat == 2'd1) begin seen = 1; dat_pend.push_back(r); end
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_beat1_seen got 0 want 1"); end
`ifdef BURST_PREEMPT_EN
    model_beats(base, 0, 1);
    model_dat(r);
    model_beats(base, 2, BL - 1);
`else
    model_beats(base, 0, BL - 1);
    model_dat(r);
`endif
    wait_quiet(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout got busy want idle"); end
    total++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin bad++; $display("FAIL mid_count got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && ob + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL mid_txn %0d got %h want %h", i, obs_q[ob + i], exp_q[eb + i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int ob, eb, n; dreq_t r; logic [31:0] base;
    ob = obs_q.size(); eb = exp_q.size();
    lat_mode = -1;
    for (int round = 0; round < 8; round++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        if (round % 2 == 0) begin
          r = rand_dreq(); dat_pend.push_back(r); model_dat(r);
        end else begin
          base = $urandom & 32'hFFFF_FFFC; ins_pend.push_back(base); model_beats(base, 0, BL - 1);
        end
      end
      wait_quiet(ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout round %0d got busy want idle", round); end
    end
    total++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin bad++; $display("FAIL b2b_count got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && ob + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL b2b_txn %0d got %h want %h", i, obs_q[ob + i], exp_q[eb + i]); end
    end
  endtask

  task automatic test_reset_midburst();
    bit ok, seen; int ob, eb;
    ob = obs_q.size(); eb = exp_q.size();
    lat_mode = 0;
    ins_pend.push_back(32'h400);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #2;
      if (ins_valid && ins_beat == 2'd2) begin
        seen = 1;
        rst_n = 0; drv_clear = 1;
        #1;
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL rstmid_outs got %h want 0", all_outs); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_beat2_seen got 0 want 1"); end
    model_beats(32'h400, 0, 2);
    repeat (2) @(negedge clk);
    #2; drv_clear = 0; rst_n = 1;
    ins_pend.push_back(32'h800);
    model_beats(32'h800, 0, BL - 1);
    wait_quiet(ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got busy want idle"); end
    total++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin bad++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && ob + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL rstmid_txn %0d got %h want %h", i, obs_q[ob + i], exp_q[eb + i]); end
    end
  endtask

  task automatic test_invariants();
    total++;
    if (spurious !== 0) begin bad++; $display("FAIL idle_strobes got %0d want 0", spurious); end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL req_stability got %0d want 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_burst(32'h200);
    test_burst(32'hFFFF_FFF8);
    test_contention();
    test_midburst_data();
    test_back_to_back();
    test_reset_midburst();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
